// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM pipeline stage and the data memory controller.
// The master drives requests; the slave (controller) drives ready and the response.
interface data_memory_ctrl_if #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [1:0]               req_size;
    logic                     req_signed;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    write_data;
    logic                     rsp_valid;
    logic [DATA_WIDTH-1:0]    rsp_data;
    logic                     rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, address, write_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, address, write_data,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressed word RAM controller: byte/half/word loads and stores with sign/zero
// extension, misalignment detection and a configurable read latency.
module data_memory_ctrl #(
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned READ_LATENCY  = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    data_memory_ctrl_if.slave bus
);
    localparam int unsigned IdxW  = ADDRESS_WIDTH - 2;
    localparam int unsigned Words = 2 ** IdxW;

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("data_memory_ctrl: DATA_WIDTH must be 32");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("data_memory_ctrl: READ_LATENCY must be in 1..4");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [IdxW-1:0]       idx_q;
    logic [1:0]            lane_q;
    logic [1:0]            size_q;
    logic                  signed_q;

    logic [DATA_WIDTH-1:0] mem [Words];

    logic                  accept;
    logic                  req_err;
    logic [IdxW-1:0]       req_idx;
    logic [1:0]            req_lane;
    logic [3:0]            wr_be;
    logic [DATA_WIDTH-1:0] wr_word;

    assign accept   = bus.req_valid & ready_q;
    assign req_idx  = bus.address[ADDRESS_WIDTH-1:2];
    assign req_lane = bus.address[1:0];

    always_comb begin
        req_err = 1'b1;
        unique case (bus.req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = bus.address[0];
            2'b10:   req_err = |bus.address[1:0];
            default: req_err = 1'b1;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone select placement.
    always_comb begin
        wr_be   = 4'b0000;
        wr_word = '0;
        unique case (bus.req_size)
            2'b00: begin
                wr_be   = 4'b0001 << req_lane;
                wr_word = {4{bus.write_data[7:0]}};
            end
            2'b01: begin
                wr_be   = 4'b0011 << req_lane;
                wr_word = {2{bus.write_data[15:0]}};
            end
            2'b10: begin
                wr_be   = 4'b1111;
                wr_word = bus.write_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (accept && bus.req_write && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[req_idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

    // With READ_LATENCY=1 the read happens on the accept edge, so use the live request fields.
    logic [IdxW-1:0]       cur_idx;
    logic [1:0]            cur_lane;
    logic [1:0]            cur_size;
    logic                  cur_signed;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic [DATA_WIDTH-1:0] load_data;

    assign cur_idx    = (state_q == StIdle) ? req_idx        : idx_q;
    assign cur_lane   = (state_q == StIdle) ? req_lane       : lane_q;
    assign cur_size   = (state_q == StIdle) ? bus.req_size   : size_q;
    assign cur_signed = (state_q == StIdle) ? bus.req_signed : signed_q;
    assign rd_word    = mem[cur_idx];
    assign rd_shift   = rd_word >> {cur_lane, 3'b000};

    always_comb begin
        load_data = rd_shift;
        unique case (cur_size)
            2'b00:   load_data = {{24{cur_signed & rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   load_data = {{16{cur_signed & rd_shift[15]}}, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_err) begin
                        state_d   = StResp;
                        rsp_err_d = 1'b1;
                    end else if (bus.req_write) begin
                        state_d = StResp;
                    end else if (READ_LATENCY == 1) begin
                        state_d    = StResp;
                        rsp_data_d = load_data;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = 3'(READ_LATENCY - 1);
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d    = StResp;
                    rsp_data_d = load_data;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= 3'd0;
            ready_q    <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            idx_q      <= '0;
            lane_q     <= 2'b00;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            if (accept) begin
                idx_q    <= req_idx;
                lane_q   <= req_lane;
                size_q   <= bus.req_size;
                signed_q <= bus.req_signed;
            end
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: a READ_LATENCY=1 and a READ_LATENCY=3 controller share clock, reset
// and request fields; sel picks which one sees req_valid and whose outputs are observed.
module tb_data_memory_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        valid = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  sz = 2'b00;
    logic        sg = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    data_memory_ctrl_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) if1 ();
    data_memory_ctrl_if #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32)) if3 ();

    assign if1.req_valid  = valid & ~sel;
    assign if3.req_valid  = valid & sel;
    assign if1.req_write  = wr;
    assign if3.req_write  = wr;
    assign if1.req_size   = sz;
    assign if3.req_size   = sz;
    assign if1.req_signed = sg;
    assign if3.req_signed = sg;
    assign if1.address    = addr;
    assign if3.address    = addr;
    assign if1.write_data = wdata;
    assign if3.write_data = wdata;

    data_memory_ctrl #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32), .READ_LATENCY(1)) dut1 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (if1)
    );
    data_memory_ctrl #(.ADDRESS_WIDTH(16), .DATA_WIDTH(32), .READ_LATENCY(3)) dut3 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (if3)
    );

    wire        o_ready = sel ? if3.req_ready : if1.req_ready;
    wire        o_rspv  = sel ? if3.rsp_valid : if1.rsp_valid;
    wire [31:0] o_data  = sel ? if3.rsp_data  : if1.rsp_data;
    wire        o_err   = sel ? if3.rsp_err   : if1.rsp_err;

    // One transaction; lat counts clock edges from accept to the sampled RspValid.
    task automatic xact(input bit s, input bit w, input logic [1:0] size, input bit sgn,
                        input logic [15:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        sel = s; wr = w; sz = size; sg = sgn; addr = a; wdata = d; valid = 1'b1;
        #1;
        n = 0;
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        lat = 1;
        while (!o_rspv && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        rd = o_data;
        er = o_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({if1.req_ready, if1.rsp_valid, if1.rsp_err, if1.rsp_data} !== 35'd0) begin
            errors++;
            $display("FAIL reset_dut1: got rdy=%b v=%b e=%b d=%h required all 0",
                     if1.req_ready, if1.rsp_valid, if1.rsp_err, if1.rsp_data);
        end
        checks++;
        if ({if3.req_ready, if3.rsp_valid, if3.rsp_err, if3.rsp_data} !== 35'd0) begin
            errors++;
            $display("FAIL reset_dut3: got rdy=%b v=%b e=%b d=%h required all 0",
                     if3.req_ready, if3.rsp_valid, if3.rsp_err, if3.rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (if1.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b required 0", if1.req_ready);
        end
        @(negedge clk);
        checks++;
        if (if1.req_ready !== 1'b1 || if3.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge: got %b/%b required 1/1", if1.req_ready,
                     if3.req_ready);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(1'b0, 1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF, rd, er, lat);
        checks++;
        if (lat !== 1 || er !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL sw_word: got lat=%0d err=%b data=%h required 1/0/00000000",
                     lat, er, rd);
        end
        xact(1'b0, 1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, rd, er, lat);
        checks++;
        if (lat !== 1 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw_word: got lat=%0d err=%b data=%h required 1/0/deadbeef",
                     lat, er, rd);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(1'b0, 1'b1, 2'b10, 1'b0, 16'h0020, 32'h11223344, rd, er, lat);
        xact(1'b0, 1'b1, 2'b00, 1'b0, 16'h0022, 32'h000000AA, rd, er, lat);
        xact(1'b0, 1'b0, 2'b10, 1'b0, 16'h0020, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h11AA3344 || er !== 1'b0) begin
            errors++;
            $display("FAIL sb_merge: got %h err=%b required 11aa3344", rd, er);
        end
        xact(1'b0, 1'b0, 2'b00, 1'b1, 16'h0022, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFFFFAA) begin
            errors++;
            $display("FAIL lb_signed: got %h required ffffffaa", rd);
        end
        xact(1'b0, 1'b0, 2'b00, 1'b0, 16'h0022, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h000000AA) begin
            errors++;
            $display("FAIL lbu: got %h required 000000aa", rd);
        end
        xact(1'b0, 1'b0, 2'b00, 1'b1, 16'h0020, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h00000044) begin
            errors++;
            $display("FAIL lb_positive: got %h required 00000044", rd);
        end
    endtask

    task automatic test_half();
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(1'b0, 1'b1, 2'b10, 1'b0, 16'h0030, 32'h5555CAFE, rd, er, lat);
        xact(1'b0, 1'b1, 2'b01, 1'b0, 16'h0032, 32'h00008001, rd, er, lat);
        xact(1'b0, 1'b0, 2'b01, 1'b1, 16'h0032, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFF8001) begin
            errors++;
            $display("FAIL lh_signed: got %h required ffff8001", rd);
        end
        xact(1'b0, 1'b0, 2'b01, 1'b0, 16'h0032, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h00008001) begin
            errors++;
            $display("FAIL lhu: got %h required 00008001", rd);
        end
        xact(1'b0, 1'b0, 2'b10, 1'b1, 16'h0030, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h8001CAFE) begin
            errors++;
            $display("FAIL sh_merge: got %h required 8001cafe", rd);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(1'b0, 1'b0, 2'b10, 1'b0, 16'h0011, 32'h0, rd, er, lat);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL lw_misaligned: got lat=%0d err=%b data=%h required 1/1/0", lat, er, rd);
        end
        xact(1'b0, 1'b1, 2'b01, 1'b0, 16'h0013, 32'h00001234, rd, er, lat);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL sh_misaligned: got lat=%0d err=%b data=%h required 1/1/0", lat, er, rd);
        end
        xact(1'b0, 1'b1, 2'b11, 1'b0, 16'h0010, 32'h00000000, rd, er, lat);
        checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL size_reserved: got lat=%0d err=%b data=%h required 1/1/0", lat, er, rd);
        end
        xact(1'b0, 1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL err_no_write: got %h err=%b required deadbeef", rd, er);
        end
    endtask

    task automatic test_latency();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [3:0]  rdy_seen;
        logic [3:0]  rspv_seen;
        logic [31:0] data3;
        xact(1'b1, 1'b1, 2'b10, 1'b0, 16'h0040, 32'hCAFEF00D, rd, er, lat);
        checks++;
        if (lat !== 1 || er !== 1'b0) begin
            errors++;
            $display("FAIL sw_lat3: got lat=%0d err=%b required 1/0", lat, er);
        end
        @(negedge clk);
        sel = 1'b1; wr = 1'b0; sz = 2'b10; sg = 1'b0; addr = 16'h0040; valid = 1'b1;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL lat3_idle_ready: got %b required 1", o_ready);
        end
        @(posedge clk);
        data3 = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rdy_seen[i]  = o_ready;
            rspv_seen[i] = o_rspv;
            if (i == 2) data3 = o_data;
        end
        checks++;
        if (rdy_seen !== 4'b1000 || rspv_seen !== 4'b0100) begin
            errors++;
            $display("FAIL lat3_timing: got ready=%b rspv=%b required 1000/0100 (cycle3..0)",
                     rdy_seen, rspv_seen);
        end
        checks++;
        if (data3 !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL lat3_data: got %h required cafef00d", data3);
        end
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL lat3_back_to_back: got ready=%b required 0", o_ready);
        end
        lat = 1;
        while (!o_rspv && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 3 || o_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL lat3_second: got lat=%0d data=%h required 3/cafef00d", lat, o_data);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          seen;
        xact(1'b1, 1'b1, 2'b10, 1'b0, 16'h0044, 32'h01020304, rd, er, lat);
        @(negedge clk);
        sel = 1'b1; wr = 1'b0; sz = 2'b10; addr = 16'h0044; valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if3.req_ready, if3.rsp_valid, if3.rsp_err, if3.rsp_data} !== 35'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got rdy=%b v=%b e=%b d=%h required all 0",
                     if3.req_ready, if3.rsp_valid, if3.rsp_err, if3.rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (if3.rsp_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_rsp: got %0d responses required 0", seen);
        end
        xact(1'b1, 1'b0, 2'b10, 1'b0, 16'h0044, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h01020304 || lat !== 3) begin
            errors++;
            $display("FAIL reset_mid_store_kept: got %h lat=%0d required 01020304/3", rd, lat);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_lanes();
        test_half();
        test_misalign();
        test_latency();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
